// File: rtl/ntt_core_wmm_dispatch_rotate_last_stage_wr_pcg_gen_pkg.sv
// Shared types and helpers for the last-stage write dispatcher of the PCG NTT core.
package ntt_core_wmm_dispatch_rotate_last_stage_wr_pcg_gen_pkg;

  localparam int LAT_MAX  = 2;
  localparam int OP_W_DEF = 32;

  typedef logic [OP_W_DEF-1:0] data_t;

  // Beat qualifiers that travel alongside the data through every stage.
  typedef struct packed {
    logic avail;
    logic sob;
    logic eob;
    logic err;
  } beat_flags_t;

  function automatic int get_latency(logic [1:0] lat_pipe_mh);
    return int'(lat_pipe_mh[0]) + int'(lat_pipe_mh[1]);
  endfunction

endpackage

// File: rtl/ntt_core_wmm_rotate_xbar.sv
// Combinational N-way barrel rotator; bwd=0 reads lane i+amt, bwd=1 reads lane i-amt.
module ntt_core_wmm_rotate_xbar #(
  parameter int N = 16,
  parameter int W = 32
) (
  input  logic [N*W-1:0]         in_data,
  input  logic                   bwd,
  input  logic [$clog2(N)-1:0]   amt,
  output logic [N*W-1:0]         out_data
);

  localparam int LOG_N = $clog2(N);

  // Index arithmetic stays LOG_N bits wide so the wrap is modulo N for free.
  function automatic logic [LOG_N-1:0] src_idx(int i, logic dir, logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] base;
    base = LOG_N'(i);
    return dir ? base - a : base + a;
  endfunction

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data[i*W +: W] = in_data[src_idx(i, bwd, amt)*W +: W];
    end
  end

endmodule

// File: rtl/blk_e120aa.sv
// Last-stage write dispatcher: position tracking, per-beat rotation, write address
// and protocol-error pulses, with 0..2 optional register stages.
module blk_e120aa
  import ntt_core_wmm_dispatch_rotate_last_stage_wr_pcg_gen_pkg::*;
#(
  parameter int               OP_W        = $bits(data_t),
  parameter int               R           = 2,
  parameter int               PSI         = 8,
  parameter int               ROT_STEP    = 1,
  parameter int               ADD_W       = 8,
  parameter logic [LAT_MAX-1:0] LAT_PIPE_MH = 2'b11
) (
  input  logic                  clk,
  input  logic                  s_rst,
  input  logic [PSI*R*OP_W-1:0] in_data,
  input  logic                  in_avail,
  input  logic                  in_sob,
  input  logic                  in_eob,
  input  logic                  in_ntt_bwd,
  output logic [PSI*R*OP_W-1:0] out_data,
  output logic [ADD_W-1:0]      out_add,
  output logic                  out_avail,
  output logic                  out_sob,
  output logic                  out_eob,
  output logic                  out_error
);

  localparam int N     = R * PSI;
  localparam int LOG_N = $clog2(N);
  localparam int DW    = N * OP_W;
  localparam int PW    = ADD_W + $clog2(ROT_STEP) + 1;
  localparam int RW    = (PW > LOG_N) ? PW : LOG_N;

  logic [ADD_W-1:0] cnt_q, cnt_d, s0_cnt;
  logic             bo_q, bo_d;
  logic             wrap_q, wrap_d;
  logic             s0_err;
  logic [RW-1:0]    rot_full;
  logic [LOG_N-1:0] s0_rot;
  beat_flags_t      s0_flags;

  // cnt_q holds the position the next in-batch beat will use; wrap_q marks that
  // it rolled over from all-ones while the batch stayed open.
  always_comb begin
    s0_cnt = '0;
    s0_err = 1'b0;
    cnt_d  = cnt_q;
    bo_d   = bo_q;
    wrap_d = wrap_q;
    if (in_avail) begin
      if (in_sob) begin
        s0_err = bo_q;
      end else if (!bo_q) begin
        s0_err = 1'b1;
      end else begin
        s0_cnt = cnt_q;
        s0_err = wrap_q;
      end
      if (in_eob) begin
        cnt_d  = '0;
        bo_d   = 1'b0;
        wrap_d = 1'b0;
      end else begin
        cnt_d  = s0_cnt + 1'b1;
        bo_d   = in_sob | bo_q;
        wrap_d = &s0_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      cnt_q  <= '0;
      bo_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bo_q   <= bo_d;
      wrap_q <= wrap_d;
    end
  end

  assign rot_full = RW'(s0_cnt) * RW'(ROT_STEP);
  assign s0_rot   = LOG_N'(rot_full);
  assign s0_flags = '{avail: in_avail, sob: in_sob, eob: in_eob, err: s0_err};

  beat_flags_t      s1_flags;
  logic             s1_bwd;
  logic [ADD_W-1:0] s1_cnt;
  logic [LOG_N-1:0] s1_rot;
  logic [DW-1:0]    s1_data;

  generate
    if (LAT_PIPE_MH[0]) begin : g_s0_s1
      beat_flags_t      flags_q;
      logic             bwd_q;
      logic [ADD_W-1:0] cnt_s1_q;
      logic [LOG_N-1:0] rot_q;
      logic [DW-1:0]    data_q;
      always_ff @(posedge clk) begin
        if (s_rst) begin
          flags_q  <= '0;
          bwd_q    <= 1'b0;
          cnt_s1_q <= '0;
          rot_q    <= '0;
          data_q   <= '0;
        end else begin
          flags_q  <= s0_flags;
          bwd_q    <= in_ntt_bwd;
          cnt_s1_q <= s0_cnt;
          rot_q    <= s0_rot;
          data_q   <= in_data;
        end
      end
      assign s1_flags = flags_q;
      assign s1_bwd   = bwd_q;
      assign s1_cnt   = cnt_s1_q;
      assign s1_rot   = rot_q;
      assign s1_data  = data_q;
    end else begin : g_s0_s1_bypass
      assign s1_flags = s0_flags;
      assign s1_bwd   = in_ntt_bwd;
      assign s1_cnt   = s0_cnt;
      assign s1_rot   = s0_rot;
      assign s1_data  = in_data;
    end
  endgenerate

  logic [DW-1:0] s1_rot_data;

  ntt_core_wmm_rotate_xbar #(
    .N (N),
    .W (OP_W)
  ) u_xbar (
    .in_data  (s1_data),
    .bwd      (s1_bwd),
    .amt      (s1_rot),
    .out_data (s1_rot_data)
  );

  beat_flags_t s2_flags;

  generate
    if (LAT_PIPE_MH[1]) begin : g_s1_s2
      beat_flags_t      flags_q;
      logic [ADD_W-1:0] add_q;
      logic [DW-1:0]    data_q;
      always_ff @(posedge clk) begin
        if (s_rst) begin
          flags_q <= '0;
          add_q   <= '0;
          data_q  <= '0;
        end else begin
          flags_q <= s1_flags;
          add_q   <= s1_cnt;
          data_q  <= s1_rot_data;
        end
      end
      assign s2_flags = flags_q;
      assign out_add  = add_q;
      assign out_data = data_q;
    end else begin : g_s1_s2_bypass
      assign s2_flags = s1_flags;
      assign out_add  = s1_cnt;
      assign out_data = s1_rot_data;
    end
  endgenerate

  assign out_avail = s2_flags.avail;
  assign out_sob   = s2_flags.sob;
  assign out_eob   = s2_flags.eob;
  assign out_error = s2_flags.err;

endmodule

// File: tb/tb_blk_e120aa.sv
// Scoreboard bench: five dispatcher instances (latency 2/0/1/1 and a 2-bit address
// variant) share one directed input stream; a monitor pops expectations per instance.
module tb_blk_e120aa;
  import ntt_core_wmm_dispatch_rotate_last_stage_wr_pcg_gen_pkg::*;

  localparam int NI = 5;
  localparam int N  = 16;
  localparam int W  = 32;
  localparam int DW = N * W;
  localparam int LAT [NI] = '{2, 0, 1, 1, 2};

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    add;
    logic          sob;
    logic          eob;
    logic          err;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          s_rst;
  logic [DW-1:0] in_data;
  logic          in_avail, in_sob, in_eob, in_ntt_bwd;

  logic [DW-1:0] o_data  [NI];
  logic [7:0]    o_add   [NI];
  logic          o_avail [NI];
  logic          o_sob   [NI];
  logic          o_eob   [NI];
  logic          o_err   [NI];
  logic [1:0]    add_a2;

  exp_t sb_q [NI][$];
  exp_t m_e;
  int   cyc = 0;
  int   tag = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blk_e120aa #(.LAT_PIPE_MH(2'b11)) u_l2 (
    .clk(clk), .s_rst(s_rst), .in_data(in_data), .in_avail(in_avail), .in_sob(in_sob),
    .in_eob(in_eob), .in_ntt_bwd(in_ntt_bwd), .out_data(o_data[0]), .out_add(o_add[0]),
    .out_avail(o_avail[0]), .out_sob(o_sob[0]), .out_eob(o_eob[0]), .out_error(o_err[0]));

  blk_e120aa #(.LAT_PIPE_MH(2'b00)) u_l0 (
    .clk(clk), .s_rst(s_rst), .in_data(in_data), .in_avail(in_avail), .in_sob(in_sob),
    .in_eob(in_eob), .in_ntt_bwd(in_ntt_bwd), .out_data(o_data[1]), .out_add(o_add[1]),
    .out_avail(o_avail[1]), .out_sob(o_sob[1]), .out_eob(o_eob[1]), .out_error(o_err[1]));

  blk_e120aa #(.LAT_PIPE_MH(2'b01)) u_l1a (
    .clk(clk), .s_rst(s_rst), .in_data(in_data), .in_avail(in_avail), .in_sob(in_sob),
    .in_eob(in_eob), .in_ntt_bwd(in_ntt_bwd), .out_data(o_data[2]), .out_add(o_add[2]),
    .out_avail(o_avail[2]), .out_sob(o_sob[2]), .out_eob(o_eob[2]), .out_error(o_err[2]));

  blk_e120aa #(.LAT_PIPE_MH(2'b10)) u_l1b (
    .clk(clk), .s_rst(s_rst), .in_data(in_data), .in_avail(in_avail), .in_sob(in_sob),
    .in_eob(in_eob), .in_ntt_bwd(in_ntt_bwd), .out_data(o_data[3]), .out_add(o_add[3]),
    .out_avail(o_avail[3]), .out_sob(o_sob[3]), .out_eob(o_eob[3]), .out_error(o_err[3]));

  blk_e120aa #(.LAT_PIPE_MH(2'b11), .ADD_W(2)) u_a2 (
    .clk(clk), .s_rst(s_rst), .in_data(in_data), .in_avail(in_avail), .in_sob(in_sob),
    .in_eob(in_eob), .in_ntt_bwd(in_ntt_bwd), .out_data(o_data[4]), .out_add(add_a2),
    .out_avail(o_avail[4]), .out_sob(o_sob[4]), .out_eob(o_eob[4]), .out_error(o_err[4]));

  assign o_add[4] = {6'b0, add_a2};

  // Lane i of a beat tagged t carries t*256 + source lane index.
  function automatic logic [DW-1:0] exp_data(int t, int cnt, bit bwd);
    logic [DW-1:0] r;
    int src;
    for (int i = 0; i < N; i++) begin
      src = bwd ? (i - (cnt % N) + N) % N : (i + cnt) % N;
      r[i*W +: W] = W'(t * 256 + src);
    end
    return r;
  endfunction

  task automatic idle();
    in_avail = 1'b0; in_sob = 1'b0; in_eob = 1'b0;
    @(posedge clk); #1;
  endtask

  // c8/e8: expected address and error for 8-bit instances; c2/e2: for the 2-bit one.
  task automatic beat(input bit sob, input bit eob, input bit bwd,
                      input int c8, input bit e8, input int c2, input bit e2);
    exp_t e;
    int   c;
    tag++;
    for (int j = 0; j < N; j++) in_data[j*W +: W] = W'(tag * 256 + j);
    in_avail = 1'b1; in_sob = sob; in_eob = eob; in_ntt_bwd = bwd;
    for (int k = 0; k < NI; k++) begin
      c      = (k == 4) ? c2 : c8;
      e.data = exp_data(tag, c, bwd);
      e.add  = 8'(c);
      e.sob  = sob;
      e.eob  = eob;
      e.err  = (k == 4) ? e2 : e8;
      e.due  = cyc + LAT[k];
      sb_q[k].push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!s_rst) begin
      for (int k = 0; k < NI; k++) begin
        if (o_avail[k]) begin
          n_chk++;
          if (sb_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat inst%0d cyc=%0d add=%0d", k, cyc, o_add[k]);
          end else begin
            m_e = sb_q[k].pop_front();
            if (o_data[k] !== m_e.data || o_add[k] !== m_e.add || o_sob[k] !== m_e.sob ||
                o_eob[k] !== m_e.eob || o_err[k] !== m_e.err || cyc != m_e.due) begin
              n_fail++;
              $display("FAIL beat inst%0d cyc=%0d got add=%0d sob=%b eob=%b err=%b want add=%0d sob=%b eob=%b err=%b cyc=%0d",
                       k, cyc, o_add[k], o_sob[k], o_eob[k], o_err[k],
                       m_e.add, m_e.sob, m_e.eob, m_e.err, m_e.due);
              if (o_data[k] !== m_e.data)
                $display("FAIL beat_data inst%0d got %h want %h", k, o_data[k], m_e.data);
            end
          end
        end else if (o_err[k] !== 1'b0) begin
          n_chk++;
          n_fail++;
          $display("FAIL error_without_avail inst%0d cyc=%0d got 1 want 0", k, cyc);
        end
        if (sb_q[k].size() > 0 && sb_q[k][0].due < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL missing_beat inst%0d due=%0d now=%0d", k, sb_q[k][0].due, cyc);
          void'(sb_q[k].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    s_rst = 1'b1; in_data = '0; in_avail = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_ntt_bwd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (o_avail[k] !== 1'b0 || o_sob[k] !== 1'b0 || o_eob[k] !== 1'b0 || o_err[k] !== 1'b0 ||
          o_add[k] !== 8'd0 || o_data[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d got avail=%b sob=%b eob=%b err=%b add=%0d, want all 0",
                 k, o_avail[k], o_sob[k], o_eob[k], o_err[k], o_add[k]);
      end
    end
    s_rst = 1'b0;

    check_int("get_latency_00", get_latency(2'b00), 0);
    check_int("get_latency_01", get_latency(2'b01), 1);
    check_int("get_latency_10", get_latency(2'b10), 1);
    check_int("get_latency_11", get_latency(2'b11), 2);

    // forward 4-beat batch
    beat(1, 0, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, 0, 1, 0);
    beat(0, 0, 0, 2, 0, 2, 0);
    beat(0, 1, 0, 3, 0, 3, 0);
    // backward batch, back-to-back after eob
    beat(1, 0, 1, 0, 0, 0, 0);
    beat(0, 0, 1, 1, 0, 1, 0);
    beat(0, 0, 1, 2, 0, 2, 0);
    beat(0, 1, 1, 3, 0, 3, 0);
    // single-beat batch, then a normal batch restarting at 0
    beat(1, 1, 0, 0, 0, 0, 0);
    beat(1, 0, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, 0, 1, 0);
    beat(0, 1, 0, 2, 0, 2, 0);
    idle();
    // eob without batch, stray beat, sob while open
    beat(0, 1, 0, 0, 1, 0, 1);
    beat(0, 0, 0, 0, 1, 0, 1);
    beat(1, 0, 0, 0, 0, 0, 0);
    beat(0, 0, 1, 1, 0, 1, 0);
    beat(1, 0, 0, 0, 1, 0, 1);
    beat(0, 1, 0, 1, 0, 1, 0);
    // idle cycles inside a batch hold the position
    beat(1, 0, 0, 0, 0, 0, 0);
    idle();
    beat(0, 0, 1, 1, 0, 1, 0);
    idle();
    idle();
    beat(0, 1, 0, 2, 0, 2, 0);
    // 6-beat batch: 2-bit address wraps on the 5th beat
    beat(1, 0, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, 0, 1, 0);
    beat(0, 0, 0, 2, 0, 2, 0);
    beat(0, 0, 0, 3, 0, 3, 0);
    beat(0, 0, 0, 4, 0, 0, 1);
    beat(0, 1, 0, 5, 0, 1, 0);
    // 18-beat batch: rotation wraps modulo 16, 2-bit address wraps repeatedly
    for (int k = 0; k < 18; k++)
      beat(k == 0, k == 17, k[0], k, 0, k % 4, (k >= 4) && (k % 4 == 0));
    // reset in the middle of a batch
    beat(1, 0, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 1, 0, 1, 0);
    s_rst = 1'b1; in_avail = 1'b0; in_sob = 1'b0; in_eob = 1'b0;
    for (int k = 0; k < NI; k++) sb_q[k].delete();
    @(posedge clk); #1;
    s_rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if (o_avail[k] !== 1'b0 || o_err[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_valid inst%0d got avail=%b err=%b want 0 0", k, o_avail[k], o_err[k]);
      end
    end
    beat(1, 0, 0, 0, 0, 0, 0);
    beat(0, 1, 1, 1, 0, 1, 0);
    repeat (4) idle();

    for (int k = 0; k < NI; k++) check_int($sformatf("queue_drained_inst%0d", k), sb_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/blk_e120aa.md
# ntt_core_wmm_dispatch_rotate_last_stage_wr_pcg_gen

Generalised last-stage write dispatcher for the PCG NTT core with matrix multiplication. It takes the `R*PSI` coefficients produced per cycle by the last butterfly stage, rotates them by a per-cycle amount derived from the position inside the batch, and issues them with a write address. Rotation direction follows the NTT direction. Pipeline depth is selected by a parameter mask, from 0 to 2 register stages, and the block reports protocol errors.

## Interface
- `OP_W`, 32: coefficient width.
- `R`, 2: radix; `R*PSI` must be a power of 2.
- `PSI`, 8: butterfly count per cycle.
- `ROT_STEP`, 1: rotation increment per valid cycle, taken modulo `R*PSI`.
- `ADD_W`, 8: write-address and position-counter width.
- `LAT_PIPE_MH`, `2'b11`: bit0 enables the S0_S1 register, bit1 enables the S1_S2 register.
- `clk`  in  1  clock.
- `s_rst`  in  1  synchronous, active-high reset.
- `in_data`  in  `PSI*R*OP_W`  coefficients; flat index `j = p*R + r`.
- `in_avail`  in  1  input valid. There is no backpressure.
- `in_sob`, `in_eob`  in  1  start and end of batch, qualified by `in_avail`.
- `in_ntt_bwd`  in  1  direction: 0 = forward, 1 = backward. Sampled with each valid beat.
- `out_data`  out  `PSI*R*OP_W`  rotated coefficients.
- `out_add`  out  `ADD_W`  write address, equal to the position in the batch.
- `out_avail`, `out_sob`, `out_eob`  out  1  delayed copies of the input flags.
- `out_error`  out  1  one-cycle protocol-error pulse.

## Operation
- Position counter `cnt` (`ADD_W` bits):
  - The beat with `in_sob` uses `cnt = 0`.
  - Each later beat uses the previous value plus 1.
  - After a beat with `in_eob`, `cnt` returns to 0.
- Batch-open flag `bo`: set by a beat with sob and without eob; cleared by a beat with eob.
- Rotation amount: `rot = (cnt*ROT_STEP) mod (R*PSI)`. Compute it in `ADD_W + log2(ROT_STEP)+1` bits, then truncate to `log2(R*PSI)` bits.
- Rotation:
  - Forward: `out[i] = in[(i + rot) mod (R*PSI)]`.
  - Backward: `out[i] = in[(i - rot) mod (R*PSI)]`.
- `out_add` equals the `cnt` used for that beat.
- sob and eob on the same beat form a single-beat batch: `cnt = 0`, identity rotation, `bo` stays 0, no error.
- Errors: `out_error` pulses for one cycle, aligned with the offending beat's output, when any of these occur:
  - sob while `bo = 1`. The counter restarts at 0.
  - eob while `bo = 0` and sob is not on the same beat. The data is still forwarded, using `cnt = 0`.
  - A valid beat with `bo = 0` and no sob. It is forwarded using `cnt = 0`.
  - `cnt` wraps from `2^ADD_W - 1` to 0 inside a batch. The beat issued at address 0 carries the error.
- Beats with `in_avail = 0` leave `cnt` and `bo` unchanged and produce `out_avail = 0`.

## Timing
- Latency is `$countones(LAT_PIPE_MH)` cycles: 0, 1 or 2.
  - Latency 0 is purely combinational from input to output.
- Stage S0_S1 registers `cnt`/`rot`, the flags, the direction and the data.
- Stage S1_S2 registers the rotated data, `out_add`, the flags and the error.
- Full throughput: one beat per cycle, with back-to-back batches allowed. An eob beat may be followed by a sob beat in the very next cycle.
- Reset values: `out_avail`, `out_sob`, `out_eob` and `out_error` are 0; `out_data` and `out_add` are 0; `cnt = 0`, `bo = 0`.
- Reset mid-batch: all pipeline valids are cleared in the reset cycle and in-flight beats are discarded. The first beat after reset must carry sob to avoid an error.

## Structure
- Package `ntt_core_wmm_dispatch_rotate_last_stage_wr_pcg_gen_pkg` holds:
  - `function int get_latency(logic [1:0] lat_pipe_mh)`, returning the popcount.
  - `localparam LAT_MAX = 2`.
  - The data typedef sized by `OP_W`.
- Sub-module `ntt_core_wmm_rotate_xbar`: purely combinational `N`-way barrel rotator, taking a direction bit and a `log2(N)`-bit amount. Instantiate it once between S0_S1 and S1_S2.
- Counter, batch flag, error logic and pipeline registers live in the top module. Each stage is generated conditionally from `LAT_PIPE_MH`.

## Test plan
Unless noted, `R=2`, `PSI=8`, `ROT_STEP=1`, `LAT_PIPE_MH=2'b11`, and `in[j]=j`.
1. Forward 4-beat batch (sob on beat 0, eob on beat 3) -> two cycles later, beat k has `out[i]=(i+k)%16` and `out_add = k`. `out_sob` is set on the first output beat, `out_eob` on the fourth. No error.
2. Same batch with `in_ntt_bwd=1` -> beat 3 has `out[0]=13` and `out[15]=12`.
3. Single beat with sob and eob -> identity output, `out_add=0`, no error; a following sob beat gets `cnt=0`.
4. eob with no open batch, then sob while a batch is open -> each gives exactly one `out_error` pulse aligned with its beat; the data is forwarded.
5. `LAT_PIPE_MH=2'b00` -> output in the same cycle. With `2'b01` and with `2'b10` -> latency 1. `get_latency` returns 0, 1 and 1 respectively.
6. `ADD_W=2` batch of 5 beats -> addresses 0,1,2,3,0, with `out_error` on the 5th beat. Assert `s_rst` mid-batch -> all valid outputs are 0 on the next cycle, then a fresh sob beat gives `out_add=0`.
